// File: rtl/reg_file_rename_pkg.sv
// Shared widths and types for the renaming architectural register file.
package reg_file_rename_pkg;

    localparam int REG_NUM_DEF = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int DATA_W      = 32;
    localparam int ROB_W_DEF   = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     data_t;

endpackage

// File: rtl/reg_file_rename_rf_read_port.sv
// One operand lookup: forwards a same-cycle matching commit and forces x0 to zero.
module rf_read_port
    import reg_file_rename_pkg::*;
#(
    parameter int ROB_W = ROB_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]     reg_value,
    input  logic                  reg_busy,
    input  logic [ROB_W-1:0]      reg_tag,
    input  logic                  bypass_en,
    input  logic                  commit_valid,
    input  logic [REG_ADDR_W-1:0] commit_rd,
    input  logic [DATA_W-1:0]     commit_res,
    input  logic [ROB_W-1:0]      commit_rob_id,
    output logic [DATA_W-1:0]     value,
    output logic                  busy,
    output logic [ROB_W-1:0]      tag
);

    logic hit;

    // Forward only when the commit would actually retire this register's current rename.
    assign hit = bypass_en && commit_valid && (commit_rd == addr) &&
                 reg_busy && (reg_tag == commit_rob_id);

    always_comb begin
        value = reg_value;
        busy  = reg_busy;
        tag   = reg_busy ? reg_tag : '0;
        if (addr == '0) begin
            value = '0;
            busy  = 1'b0;
            tag   = '0;
        end else if (hit) begin
            value = commit_res;
            busy  = 1'b0;
            tag   = '0;
        end
    end

endmodule

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register ROB rename tags, commit write-back,
// flush of all renames, and two combinational operand lookup ports with commit bypass.
module reg_file_rename
    import reg_file_rename_pkg::*;
#(
    parameter int REG_NUM = REG_NUM_DEF,
    parameter int ROB_W   = ROB_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  flush,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [ROB_W-1:0]      issue_rob_id,
    input  logic                  commit_valid,
    input  logic [REG_ADDR_W-1:0] commit_rd,
    input  logic [DATA_W-1:0]     commit_res,
    input  logic [ROB_W-1:0]      commit_rob_id,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0]     rs1_value,
    output logic                  rs1_busy,
    output logic [ROB_W-1:0]      rs1_tag,
    output logic [DATA_W-1:0]     rs2_value,
    output logic                  rs2_busy,
    output logic [ROB_W-1:0]      rs2_tag
);

    data_t            value_q [REG_NUM];
    logic             busy_q  [REG_NUM];
    logic [ROB_W-1:0] tag_q   [REG_NUM];

    logic do_commit;
    logic do_issue;
    logic commit_clears;

    assign do_commit     = rdy && commit_valid && (commit_rd != '0);
    assign do_issue      = rdy && issue_valid && (issue_rd != '0) && !flush;
    assign commit_clears = busy_q[commit_rd] && (tag_q[commit_rd] == commit_rob_id);

    // Later assignments win: commit clears, a same-rd issue re-renames, flush drops everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                value_q[i] <= '0;
                busy_q[i]  <= 1'b0;
                tag_q[i]   <= '0;
            end
        end else if (rdy) begin
            if (do_commit) begin
                value_q[commit_rd] <= commit_res;
                if (commit_clears) begin
                    busy_q[commit_rd] <= 1'b0;
                    tag_q[commit_rd]  <= '0;
                end
            end
            if (do_issue) begin
                busy_q[issue_rd] <= 1'b1;
                tag_q[issue_rd]  <= issue_rob_id;
            end
            if (flush) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    busy_q[i] <= 1'b0;
                    tag_q[i]  <= '0;
                end
            end
        end
    end

    logic bypass_en;
    assign bypass_en = rdy && !flush;

    rf_read_port #(.ROB_W(ROB_W)) u_rs1 (
        .addr          (rs1_addr),
        .reg_value     (value_q[rs1_addr]),
        .reg_busy      (busy_q[rs1_addr]),
        .reg_tag       (tag_q[rs1_addr]),
        .bypass_en     (bypass_en),
        .commit_valid  (commit_valid),
        .commit_rd     (commit_rd),
        .commit_res    (commit_res),
        .commit_rob_id (commit_rob_id),
        .value         (rs1_value),
        .busy          (rs1_busy),
        .tag           (rs1_tag)
    );

    rf_read_port #(.ROB_W(ROB_W)) u_rs2 (
        .addr          (rs2_addr),
        .reg_value     (value_q[rs2_addr]),
        .reg_busy      (busy_q[rs2_addr]),
        .reg_tag       (tag_q[rs2_addr]),
        .bypass_en     (bypass_en),
        .commit_valid  (commit_valid),
        .commit_rd     (commit_rd),
        .commit_res    (commit_res),
        .commit_rob_id (commit_rob_id),
        .value         (rs2_value),
        .busy          (rs2_busy),
        .tag           (rs2_tag)
    );

endmodule

// File: tb/tb_reg_file_rename.sv
// Directed checks of rename, commit, bypass, x0, flush and stall behaviour.
module tb_reg_file_rename;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  issue_rob_id;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_res;
    logic [4:0]  commit_rob_id;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_value;
    logic        rs1_busy;
    logic [4:0]  rs1_tag;
    logic [31:0] rs2_value;
    logic        rs2_busy;
    logic [4:0]  rs2_tag;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    reg_file_rename dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .flush         (flush),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_rob_id  (issue_rob_id),
        .commit_valid  (commit_valid),
        .commit_rd     (commit_rd),
        .commit_res    (commit_res),
        .commit_rob_id (commit_rob_id),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_value     (rs1_value),
        .rs1_busy      (rs1_busy),
        .rs1_tag       (rs1_tag),
        .rs2_value     (rs2_value),
        .rs2_busy      (rs2_busy),
        .rs2_tag       (rs2_tag)
    );

    // Inputs change just after a falling edge; one tick crosses exactly one rising edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        flush        = 1'b0;
        issue_valid  = 1'b0;
        commit_valid = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [4:0] id);
        issue_valid  = 1'b1;
        issue_rd     = rd;
        issue_rob_id = id;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [4:0] id, input logic [31:0] res);
        commit_valid  = 1'b1;
        commit_rd     = rd;
        commit_rob_id = id;
        commit_res    = res;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; idle();
        issue_rd = '0; issue_rob_id = '0; commit_rd = '0; commit_rob_id = '0; commit_res = '0;
        rs1_addr = 5'd5; rs2_addr = 5'd31;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({rs1_value, rs1_busy, rs1_tag} !== {32'h0, 1'b0, 5'd0}) begin
            fails++;
            $display("[TB] FAIL reset_rs1: got %h/%b/%0d expected 0/0/0", rs1_value, rs1_busy, rs1_tag);
        end
        checks++;
        if ({rs2_value, rs2_busy, rs2_tag} !== {32'h0, 1'b0, 5'd0}) begin
            fails++;
            $display("[TB] FAIL reset_rs2: got %h/%b/%0d expected 0/0/0", rs2_value, rs2_busy, rs2_tag);
        end
    endtask

    task automatic test_bypass();
        issue(5'd5, 5'd3);
        tick();
        idle();
        rs1_addr = 5'd5;
        #1;
        checks++;
        if ({rs1_value, rs1_busy, rs1_tag} !== {32'h0, 1'b1, 5'd3}) begin
            fails++;
            $display("[TB] FAIL rename_x5: got %h/%b/%0d expected 0/1/3", rs1_value, rs1_busy, rs1_tag);
        end
        commit(5'd5, 5'd3, 32'hDEADBEEF);
        #1;
        checks++;
        if ({rs1_value, rs1_busy, rs1_tag} !== {32'hDEADBEEF, 1'b0, 5'd0}) begin
            fails++;
            $display("[TB] FAIL bypass_x5: got %h/%b/%0d expected deadbeef/0/0", rs1_value, rs1_busy, rs1_tag);
        end
        tick();
        idle();
        #1;
        checks++;
        if ({rs1_value, rs1_busy, rs1_tag} !== {32'hDEADBEEF, 1'b0, 5'd0}) begin
            fails++;
            $display("[TB] FAIL committed_x5: got %h/%b/%0d expected deadbeef/0/0", rs1_value, rs1_busy, rs1_tag);
        end
    endtask

    task automatic test_newer_rename();
        issue(5'd7, 5'd2);
        tick();
        issue(5'd7, 5'd4);
        tick();
        idle();
        commit(5'd7, 5'd2, 32'h11);
        rs1_addr = 5'd7;
        #1;
        checks++;
        if ({rs1_value, rs1_busy, rs1_tag} !== {32'h0, 1'b1, 5'd4}) begin
            fails++;
            $display("[TB] FAIL stale_no_bypass_x7: got %h/%b/%0d expected 0/1/4", rs1_value, rs1_busy, rs1_tag);
        end
        tick();
        idle();
        #1;
        checks++;
        if ({rs1_value, rs1_busy, rs1_tag} !== {32'h11, 1'b1, 5'd4}) begin
            fails++;
            $display("[TB] FAIL stale_commit_x7: got %h/%b/%0d expected 11/1/4", rs1_value, rs1_busy, rs1_tag);
        end
    endtask

    task automatic test_issue_commit_same_rd();
        issue(5'd9, 5'd5);
        tick();
        issue(5'd9, 5'd6);
        commit(5'd9, 5'd5, 32'h22);
        rs1_addr = 5'd9;
        #1;
        checks++;
        if ({rs1_value, rs1_busy, rs1_tag} !== {32'h22, 1'b0, 5'd0}) begin
            fails++;
            $display("[TB] FAIL same_cycle_read_x9: got %h/%b/%0d expected 22/0/0", rs1_value, rs1_busy, rs1_tag);
        end
        tick();
        idle();
        #1;
        checks++;
        if ({rs1_value, rs1_busy, rs1_tag} !== {32'h22, 1'b1, 5'd6}) begin
            fails++;
            $display("[TB] FAIL issue_wins_x9: got %h/%b/%0d expected 22/1/6", rs1_value, rs1_busy, rs1_tag);
        end
        commit(5'd9, 5'd6, 32'h44);
        tick();
        idle();
        #1;
        checks++;
        if ({rs1_value, rs1_busy, rs1_tag} !== {32'h44, 1'b0, 5'd0}) begin
            fails++;
            $display("[TB] FAIL final_commit_x9: got %h/%b/%0d expected 44/0/0", rs1_value, rs1_busy, rs1_tag);
        end
    endtask

    task automatic test_x0();
        issue(5'd0, 5'd1);
        commit(5'd0, 5'd1, 32'hFF);
        rs1_addr = 5'd0;
        #1;
        checks++;
        if ({rs1_value, rs1_busy, rs1_tag} !== {32'h0, 1'b0, 5'd0}) begin
            fails++;
            $display("[TB] FAIL x0_same_cycle: got %h/%b/%0d expected 0/0/0", rs1_value, rs1_busy, rs1_tag);
        end
        tick();
        idle();
        #1;
        checks++;
        if ({rs1_value, rs1_busy, rs1_tag} !== {32'h0, 1'b0, 5'd0}) begin
            fails++;
            $display("[TB] FAIL x0_after: got %h/%b/%0d expected 0/0/0", rs1_value, rs1_busy, rs1_tag);
        end
    endtask

    task automatic test_flush();
        issue(5'd3, 5'd7);
        tick();
        issue(5'd4, 5'd8);
        tick();
        idle();
        flush = 1'b1;
        commit(5'd3, 5'd7, 32'h33);
        issue(5'd8, 5'd9);
        rs1_addr = 5'd3;
        rs2_addr = 5'd4;
        #1;
        checks++;
        if ({rs1_value, rs1_busy, rs1_tag} !== {32'h0, 1'b1, 5'd7}) begin
            fails++;
            $display("[TB] FAIL flush_no_bypass_x3: got %h/%b/%0d expected 0/1/7", rs1_value, rs1_busy, rs1_tag);
        end
        tick();
        idle();
        #1;
        checks++;
        if ({rs1_value, rs1_busy, rs1_tag} !== {32'h33, 1'b0, 5'd0}) begin
            fails++;
            $display("[TB] FAIL flush_x3: got %h/%b/%0d expected 33/0/0", rs1_value, rs1_busy, rs1_tag);
        end
        checks++;
        if ({rs2_value, rs2_busy, rs2_tag} !== {32'h0, 1'b0, 5'd0}) begin
            fails++;
            $display("[TB] FAIL flush_x4: got %h/%b/%0d expected 0/0/0", rs2_value, rs2_busy, rs2_tag);
        end
        rs2_addr = 5'd8;
        #1;
        checks++;
        if ({rs2_value, rs2_busy, rs2_tag} !== {32'h0, 1'b0, 5'd0}) begin
            fails++;
            $display("[TB] FAIL flush_drops_issue_x8: got %h/%b/%0d expected 0/0/0", rs2_value, rs2_busy, rs2_tag);
        end
    endtask

    task automatic test_stall();
        issue(5'd11, 5'd12);
        tick();
        idle();
        rdy = 1'b0;
        issue(5'd10, 5'd10);
        commit(5'd11, 5'd12, 32'h99);
        rs1_addr = 5'd11;
        rs2_addr = 5'd10;
        #1;
        checks++;
        if ({rs1_value, rs1_busy, rs1_tag} !== {32'h0, 1'b1, 5'd12}) begin
            fails++;
            $display("[TB] FAIL stall_no_bypass_x11: got %h/%b/%0d expected 0/1/12", rs1_value, rs1_busy, rs1_tag);
        end
        tick();
        #1;
        checks++;
        if ({rs1_value, rs1_busy, rs1_tag} !== {32'h0, 1'b1, 5'd12}) begin
            fails++;
            $display("[TB] FAIL stall_hold_x11: got %h/%b/%0d expected 0/1/12", rs1_value, rs1_busy, rs1_tag);
        end
        checks++;
        if ({rs2_value, rs2_busy, rs2_tag} !== {32'h0, 1'b0, 5'd0}) begin
            fails++;
            $display("[TB] FAIL stall_hold_x10: got %h/%b/%0d expected 0/0/0", rs2_value, rs2_busy, rs2_tag);
        end
        idle();
        flush = 1'b1;
        tick();
        idle();
        #1;
        checks++;
        if ({rs1_value, rs1_busy, rs1_tag} !== {32'h0, 1'b1, 5'd12}) begin
            fails++;
            $display("[TB] FAIL stall_flush_ignored_x11: got %h/%b/%0d expected 0/1/12", rs1_value, rs1_busy, rs1_tag);
        end
        rdy = 1'b1;
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_newer_rename();
        test_issue_commit_same_rd();
        test_x0();
        test_flush();
        test_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
